// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes and state encoding for the ALU responder
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_MOD = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic is_iter_op(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
   endfunction

endpackage

// File: rtl/alu_seq_resp_if.sv
// rtl/alu_seq_resp_if.sv - request/response channel bundle of the ALU responder
interface alu_seq_resp_if #(
   parameter int WIDTH = 8,
   parameter int RES_W = 4 * WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [RES_W-1:0] out_res;
   logic             out_err;

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_res, out_err
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_res, out_err
   );
endinterface

// File: rtl/alu_iter_core.sv
// rtl/alu_iter_core.sv - shift-add multiply and restoring divide datapath
// Next-step values are exported so the top can register the final result on the last step edge.
module alu_iter_core #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               op_is_mul,
   input  logic               step,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] prod_next,
   output logic [WIDTH-1:0]   quo_next,
   output logic [WIDTH-1:0]   rem_next
);

   logic               is_mul;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   sreg;      // multiplier bits (MUL) or dividend/quotient bits (DIV)
   logic [WIDTH:0]     rem;
   logic [WIDTH-1:0]   divisor;

   logic [2*WIDTH-1:0] acc_n;
   logic [WIDTH:0]     shifted;
   logic [WIDTH+1:0]   diff;
   logic               fits;
   logic [WIDTH:0]     rem_n;
   logic [WIDTH-1:0]   quo_n;

   always_comb begin
      acc_n   = sreg[0] ? (acc + mcand) : acc;
      shifted = {rem[WIDTH-1:0], sreg[WIDTH-1]};
      diff    = {1'b0, shifted} - {2'b00, divisor};
      fits    = ~diff[WIDTH+1];
      rem_n   = fits ? diff[WIDTH:0] : shifted;
      quo_n   = {sreg[WIDTH-2:0], fits};
   end

   assign prod_next = acc_n;
   assign quo_next  = quo_n;
   assign rem_next  = rem_n[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_mul  <= 1'b0;
         acc     <= '0;
         mcand   <= '0;
         sreg    <= '0;
         rem     <= '0;
         divisor <= '0;
      end else if (start) begin
         is_mul  <= op_is_mul;
         acc     <= '0;
         mcand   <= {{WIDTH{1'b0}}, a};
         sreg    <= op_is_mul ? b : a;
         rem     <= '0;
         divisor <= b;
      end else if (step) begin
         if (is_mul) begin
            acc   <= acc_n;
            mcand <= mcand << 1;
            sreg  <= sreg >> 1;
         end else begin
            rem   <= rem_n;
            sreg  <= quo_n;
         end
      end
   end

endmodule

// File: rtl/alu_seq_resp.sv
// rtl/alu_seq_resp.sv - multicycle ALU responder: FSM, handshakes and result registers
module alu_seq_resp
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int RES_W = 4 * WIDTH
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_seq_resp_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   state_t             state;
   logic               armed;
   logic [CW-1:0]      cnt;
   logic [2:0]         op_q;
   logic               accept;
   logic               div_zero;
   logic               start;
   logic [2*WIDTH-1:0] prod_next;
   logic [WIDTH-1:0]   quo_next;
   logic [WIDTH-1:0]   rem_next;
   logic [RES_W-1:0]   calc_res;

   // armed keeps in_ready low while reset is held even though state sits in IDLE
   assign bus.in_ready  = armed && (state == ST_IDLE);
   assign bus.out_valid = (state == ST_DONE);

   assign accept   = bus.in_valid && bus.in_ready;
   assign div_zero = ((bus.in_op == OP_DIV) || (bus.in_op == OP_MOD)) && (bus.in_b == '0);
   assign start    = accept && is_iter_op(bus.in_op) && !div_zero;

   alu_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op_is_mul (bus.in_op == OP_MUL),
      .step      (state == ST_CALC),
      .a         (bus.in_a),
      .b         (bus.in_b),
      .prod_next (prod_next),
      .quo_next  (quo_next),
      .rem_next  (rem_next)
   );

   always_comb begin
      calc_res = '0;
      case (op_q)
         OP_MUL:  calc_res = RES_W'(prod_next);
         OP_DIV:  calc_res = RES_W'(quo_next);
         default: calc_res = RES_W'(rem_next);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         armed       <= 1'b0;
         cnt         <= '0;
         op_q        <= '0;
         bus.out_res <= '0;
         bus.out_err <= 1'b0;
      end else begin
         armed <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q <= bus.in_op;
                  if (start) begin
                     cnt   <= CW'(WIDTH - 1);
                     state <= ST_CALC;
                  end else begin
                     state <= ST_DONE;
                     case (bus.in_op)
                        OP_ADD: begin
                           bus.out_res <= RES_W'(bus.in_a) + RES_W'(bus.in_b);
                           bus.out_err <= 1'b0;
                        end
                        OP_SUB: begin
                           bus.out_res <= RES_W'(bus.in_a) - RES_W'(bus.in_b);
                           bus.out_err <= 1'b0;
                        end
                        OP_DIV, OP_MOD: begin
                           bus.out_res <= '1;
                           bus.out_err <= 1'b1;
                        end
                        default: begin
                           bus.out_res <= '0;
                           bus.out_err <= 1'b1;
                        end
                     endcase
                  end
               end
            end
            ST_CALC: begin
               if (cnt == '0) begin
                  bus.out_res <= calc_res;
                  bus.out_err <= 1'b0;
                  state       <= ST_DONE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_DONE: begin
               if (bus.out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_resp.sv
// tb/tb_alu_seq_resp.sv - directed vector bench for alu_seq_resp
module tb_alu_seq_resp;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [31:0] res;
      logic        err;
      int          lat;
   } vec_t;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   logic watch_stale;
   logic stale_seen;

   alu_seq_resp_if #(.WIDTH(8), .RES_W(32)) bus ();

   alu_seq_resp #(.WIDTH(8), .RES_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (watch_stale && bus.out_valid && bus.out_res == 32'd143) stale_seen = 1'b1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic run_vec(input vec_t v);
      int d;
      bus.in_valid = 1'b1;
      bus.in_op    = v.op;
      bus.in_a     = v.a;
      bus.in_b     = v.b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_op    = 3'($urandom);
      bus.in_a     = 8'($urandom);
      bus.in_b     = 8'($urandom);
      d = 0;
      forever begin
         @(negedge clk);
         if (d == 0) chk({v.name, " in_ready busy"}, 64'(bus.in_ready), 64'd0);
         if (bus.out_valid || d > 40) break;
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.in_op    = 3'($urandom);
         bus.in_a     = 8'($urandom);
         bus.in_b     = 8'($urandom);
         d++;
      end
      bus.in_valid = 1'b0;
      chk({v.name, " latency"}, 64'(d), 64'(v.lat));
      chk({v.name, " res"}, 64'(bus.out_res), 64'(v.res));
      chk({v.name, " err"}, 64'(bus.out_err), 64'(v.err));
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({v.name, " back to idle"}, {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
   endtask

   vec_t vecs[$];
   vec_t v;
   logic stable;

   initial begin
      errors        = 0;
      checks        = 0;
      watch_stale   = 1'b0;
      stale_seen    = 1'b0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_op     = 3'd0;
      bus.in_a      = 8'd0;
      bus.in_b      = 8'd0;
      bus.out_ready = 1'b0;

      vecs.push_back('{"add",      3'b000, 8'd200, 8'd100, 32'd300,        1'b0, 0});
      vecs.push_back('{"sub",      3'b001, 8'd3,   8'd5,   32'hFFFF_FFFE,  1'b0, 0});
      vecs.push_back('{"add_max",  3'b000, 8'd255, 8'd255, 32'd510,        1'b0, 0});
      vecs.push_back('{"mul_max",  3'b010, 8'd255, 8'd255, 32'd65025,      1'b0, 8});
      vecs.push_back('{"mul_13_11",3'b010, 8'd13,  8'd11,  32'd143,        1'b0, 8});
      vecs.push_back('{"div",      3'b011, 8'd200, 8'd7,   32'd28,         1'b0, 8});
      vecs.push_back('{"mod",      3'b100, 8'd200, 8'd7,   32'd4,          1'b0, 8});
      vecs.push_back('{"div_small",3'b011, 8'd7,   8'd200, 32'd0,          1'b0, 8});
      vecs.push_back('{"mod_big",  3'b100, 8'd255, 8'd16,  32'd15,         1'b0, 8});
      vecs.push_back('{"div_max",  3'b011, 8'd255, 8'd1,   32'd255,        1'b0, 8});
      vecs.push_back('{"div_zero", 3'b011, 8'd9,   8'd0,   32'hFFFF_FFFF,  1'b1, 0});
      vecs.push_back('{"mod_zero", 3'b100, 8'd5,   8'd0,   32'hFFFF_FFFF,  1'b1, 0});
      vecs.push_back('{"ill_110",  3'b110, 8'd1,   8'd2,   32'd0,          1'b1, 0});
      vecs.push_back('{"ill_111",  3'b111, 8'd1,   8'd2,   32'd0,          1'b1, 0});

      // reset and idle
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset outputs", {60'd0, bus.in_ready, bus.out_valid, bus.out_err, 1'b0} | 64'(bus.out_res), 64'd0);
      end
      rst_n = 1'b1;
      #1;
      chk("ready before first edge", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      chk("ready after release", 64'(bus.in_ready), 64'd1);

      foreach (vecs[i]) run_vec(vecs[i]);

      // back-pressure hold with in_valid noise
      bus.in_valid = 1'b1;
      bus.in_op    = 3'b000;
      bus.in_a     = 8'd10;
      bus.in_b     = 8'd20;
      @(negedge clk);
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.in_a     = 8'($urandom);
         @(negedge clk);
         if (!(bus.out_valid && !bus.in_ready && bus.out_res == 32'd30 && !bus.out_err)) stable = 1'b0;
      end
      chk("backpressure stable", 64'(stable), 64'd1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("backpressure release", {62'd0, bus.in_ready, bus.out_valid}, 64'b10);

      // reset in the middle of a multiply
      watch_stale  = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_op    = 3'b010;
      bus.in_a     = 8'd13;
      bus.in_b     = 8'd11;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midop reset clears", {60'd0, bus.in_ready, bus.out_valid, bus.out_err, 1'b0} | 64'(bus.out_res), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      v = '{"add_after_rst", 3'b000, 8'd1, 8'd1, 32'd2, 1'b0, 0};
      run_vec(v);
      repeat (10) @(negedge clk);
      chk("no stale 143", 64'(stale_seen), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
